// File: rtl/serial_pair_tx.sv
// Parallel-load, two-lane serialiser: shifts an operand pair out one bit per
// cycle with frame markers, a pause input and a one-cycle completion pulse.
module serial_pair_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             hold,
    output logic             a_bit,
    output logic             b_bit,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             done
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] word_a;
    logic [WIDTH-1:0] word_b;
    logic             held_a;
    logic             held_b;

    logic [CW-1:0]    idx;
    logic             cur_a;
    logic             cur_b;
    logic             shifting;
    logic             advance;

    always_comb begin
        idx   = (MSB_FIRST != 0) ? (LAST - cnt) : cnt;
        cur_a = word_a[idx];
        cur_b = word_b[idx];
    end

    assign shifting = (state == SHIFT);
    assign advance  = shifting & ~hold;

    // While paused the lanes show the last bit pair actually presented.
    assign a_bit      = shifting & (hold ? held_a : cur_a);
    assign b_bit      = shifting & (hold ? held_b : cur_b);
    assign bit_valid  = advance;
    assign first_bit  = advance & (cnt == '0);
    assign last_bit   = advance & (cnt == LAST);
    assign load_ready = (state == IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            word_a <= '0;
            word_b <= '0;
            held_a <= 1'b0;
            held_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        word_a <= a_in;
                        word_b <= b_in;
                        cnt    <= '0;
                        held_a <= 1'b0;
                        held_b <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!hold) begin
                        held_a <= cur_a;
                        held_b <= cur_b;
                        if (cnt == LAST) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pair_tx.sv
// Bench for serial_pair_tx at WIDTH=4, MSB-first and LSB-first instances
// side by side, checked against a frame-level model and literal sequences.
module tb_serial_pair_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       lv;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       hold;

    logic rdy_m, am, bm, vm, fm, lm, dm;
    logic rdy_l, al, bl, vl, fl, ll, dl;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_pair_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(rst), .load_valid(lv), .load_ready(rdy_m),
        .a_in(a_in), .b_in(b_in), .hold(hold),
        .a_bit(am), .b_bit(bm), .bit_valid(vm),
        .first_bit(fm), .last_bit(lm), .done(dm)
    );

    serial_pair_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(rst), .load_valid(lv), .load_ready(rdy_l),
        .a_in(a_in), .b_in(b_in), .hold(hold),
        .a_bit(al), .b_bit(bl), .bit_valid(vl),
        .first_bit(fl), .last_bit(ll), .done(dl)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic bitof(input logic [3:0] w, input int k, input bit msb);
        return msb ? w[3-k] : w[k];
    endfunction

    // Frame-level model: busy while bit pairs remain, k = pairs already sent.
    bit         m_ok = 0;
    bit         m_busy, m_done;
    int         m_k;
    logic [3:0] m_wa, m_wb;
    logic       pam, pbm, pal, pbl;

    always @(posedge clk) begin
        if (!rst) begin
            m_ok = 1; m_busy = 0; m_done = 0; m_k = 0; m_wa = '0; m_wb = '0;
            pam = 0; pbm = 0; pal = 0; pbl = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (lv) begin
                m_busy = 1; m_k = 0; m_wa = a_in; m_wb = b_in;
                pam = 0; pbm = 0; pal = 0; pbl = 0;
            end
        end else if (!hold) begin
            pam = bitof(m_wa, m_k, 1); pbm = bitof(m_wb, m_k, 1);
            pal = bitof(m_wa, m_k, 0); pbl = bitof(m_wb, m_k, 0);
            if (m_k == 3) begin
                m_busy = 0; m_done = 1;
            end else begin
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            automatic bit ev = m_busy && !hold;
            chk("m ready", rdy_m, !m_busy && !m_done);
            chk("l ready", rdy_l, !m_busy && !m_done);
            chk("m valid", vm, ev);
            chk("l valid", vl, ev);
            chk("m first", fm, ev && m_k == 0);
            chk("l first", fl, ev && m_k == 0);
            chk("m last", lm, ev && m_k == 3);
            chk("l last", ll, ev && m_k == 3);
            chk("m done", dm, m_done);
            chk("l done", dl, m_done);
            if (!m_done) begin
                chk("m a_bit", am, m_busy ? (hold ? pam : bitof(m_wa, m_k, 1)) : 1'b0);
                chk("m b_bit", bm, m_busy ? (hold ? pbm : bitof(m_wb, m_k, 1)) : 1'b0);
                chk("l a_bit", al, m_busy ? (hold ? pal : bitof(m_wa, m_k, 0)) : 1'b0);
                chk("l b_bit", bl, m_busy ? (hold ? pbl : bitof(m_wb, m_k, 0)) : 1'b0);
            end
        end
    end

    task automatic drv(input logic r, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic h);
        @(posedge clk);
        #1;
        rst = r; lv = v; a_in = a; b_in = b; hold = h;
    endtask

    logic [3:0] seq_am, seq_bm, seq_al, seq_bl;
    int pairs, dones;

    initial begin
        rst = 1'b0; lv = 1'b0; a_in = '0; b_in = '0; hold = 1'b0;
        seq_am = 4'b1010; seq_bm = 4'b1001;
        seq_al = 4'b0101; seq_bl = 4'b1001;

        drv(0, 1, 4'hF, 4'hF, 1);
        drv(0, 1, 4'hF, 4'hF, 0);
        @(negedge clk);
        chk("rst ready", rdy_m, 1);
        chk("rst valid", vm, 0);
        chk("rst done", dm, 0);
        chk("rst a_bit", am, 0);

        // Plain frame, both bit orders.
        drv(1, 1, 4'b1010, 4'b1001, 0);
        for (int c = 1; c <= 6; c++) begin
            drv(1, 0, '0, '0, 0);
            @(negedge clk);
            if (c <= 4) begin
                chk("A m pair", {am, bm}, {seq_am[4-c], seq_bm[4-c]});
                chk("A l pair", {al, bl}, {seq_al[4-c], seq_bl[4-c]});
            end
            chk("A first", fm, c == 1);
            chk("A last", lm, c == 4);
            chk("A done", dm, c == 5);
            chk("A ready", rdy_m, c == 6);
        end

        // Pause on cycles 2-3.
        drv(1, 1, 4'b1010, 4'b1001, 0);
        for (int c = 1; c <= 8; c++) begin
            drv(1, 0, '0, '0, (c == 2 || c == 3));
            @(negedge clk);
            if (c == 2 || c == 3) begin
                chk("B hold valid", vm, 0);
                chk("B hold pair", {am, bm}, 2'b11);
            end
            if (c == 4) begin
                chk("B resume valid", vm, 1);
                chk("B resume pair", {am, bm}, 2'b00);
            end
            chk("B done", dm, c == 7);
        end

        // load_valid held high with changing operands during the frame.
        drv(1, 1, 4'b1010, 4'b1001, 0);
        for (int c = 1; c <= 12; c++) begin
            drv(1, c <= 6, 4'b0101, 4'b0110, 0);
            @(negedge clk);
            if (c <= 4) chk("C m pair", {am, bm}, {seq_am[4-c], seq_bm[4-c]});
            if (c == 6) chk("C ready", rdy_m, 1);
            chk("C done", dm, (c == 5 || c == 11));
        end

        // Reset in the middle of a frame.
        drv(1, 1, 4'b1010, 4'b1001, 0);
        for (int c = 1; c <= 8; c++) begin
            drv(c != 2, 0, '0, '0, 0);
            @(negedge clk);
            if (c == 3) begin
                chk("D ready", rdy_m, 1);
                chk("D valid", vm, 0);
            end
            chk("D done", dm, 0);
        end

        // Back-to-back all-ones frames.
        pairs = 0; dones = 0;
        drv(1, 1, 4'hF, 4'hF, 0);
        for (int c = 1; c <= 12; c++) begin
            drv(1, c <= 6, 4'hF, 4'hF, 0);
            @(negedge clk);
            if (vm && am && bm) pairs++;
            if (dm) dones++;
        end
        chk("E pairs", pairs, 8);
        chk("E dones", dones, 2);

        drv(1, 0, '0, '0, 0);
        drv(1, 0, '0, '0, 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
